spi_pw_host: RTL and testbench

Host end of the SPI protocol-wrapper (pw) bus. It takes byte events from the SPI slave byte core, which already runs in the clk domain. It broadcasts them to N pw clients as write data, command flags and end-of-transaction events. It arbitrates the clients' pw_req lines and returns the granted client's response bytes to the SPI slave through a small TX FIFO. All pw command handlers (loopback, register access, memory bridge) sit behind this block.

---
 rtl/spi_pw_host.sv | 121 ++++++++++++
 tb/tb_spi_pw_host.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_pw_host.sv
// Host end of the SPI protocol-wrapper bus: broadcasts received bytes to pw clients,
// arbitrates their requests and queues the granted client's responses for the SPI slave.
module spi_pw_host #(
  parameter int unsigned N_CLIENTS       = 4,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             sb_rx_data,
  input  logic                   sb_rx_first,
  input  logic                   sb_rx_stb,
  input  logic                   sb_cs_end,
  output logic [7:0]             sb_tx_data,
  output logic                   sb_tx_valid,
  input  logic                   sb_tx_ack,
  output logic [7:0]             pw_wdata,
  output logic                   pw_wcmd,
  output logic                   pw_wstb,
  output logic                   pw_end,
  input  logic [N_CLIENTS-1:0]   pw_req,
  output logic [N_CLIENTS-1:0]   pw_gnt,
  input  logic [8*N_CLIENTS-1:0] pw_rdata,
  input  logic [N_CLIENTS-1:0]   pw_rstb,
  output logic                   ovf
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned PTR_W = FIFO_DEPTH_LOG2;
  localparam int unsigned CNT_W = FIFO_DEPTH_LOG2 + 1;

  logic [7:0]           r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     w_count_nxt;
  logic [N_CLIENTS-1:0] w_req_low;
  logic [7:0]           w_rbyte;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_do_push;
  logic                 w_drop;

  // Write/end path: one-cycle registered broadcast of SPI slave events.
  always_ff @(posedge clk) begin
    if (rst) begin
      pw_wdata <= '0;
      pw_wcmd  <= 1'b0;
      pw_wstb  <= 1'b0;
      pw_end   <= 1'b0;
    end else begin
      pw_wstb <= sb_rx_stb;
      pw_end  <= sb_cs_end;
      if (sb_rx_stb) begin
        pw_wdata <= sb_rx_data;
        pw_wcmd  <= sb_rx_first;
      end
    end
  end

  // Fixed-priority arbiter; a grant is held until the transaction ends.
  assign w_req_low = pw_req & (~pw_req + N_CLIENTS'(1));

  always_ff @(posedge clk) begin
    if (rst || pw_end) begin
      pw_gnt <= '0;
    end else if (pw_gnt == '0) begin
      pw_gnt <= w_req_low;
    end
  end

  always_comb begin
    w_rbyte = '0;
    for (int i = 0; i < int'(N_CLIENTS); i++) begin
      if (pw_gnt[i]) w_rbyte = pw_rdata[8*i +: 8];
    end
  end

  // Transfer-end flush overrides any push or pop in the same cycle.
  assign w_push    = (|(pw_rstb & pw_gnt)) && !pw_end;
  assign w_pop     = sb_tx_ack && sb_tx_valid && !pw_end;
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_push = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_do_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || pw_end) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      sb_tx_valid <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_drop)    ovf      <= 1'b1;
      r_count     <= w_count_nxt;
      sb_tx_valid <= (w_count_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= w_rbyte;
    end
  end

  assign sb_tx_data = r_mem[r_rd_ptr];

endmodule

// File: tb/tb_spi_pw_host.sv
// Self-checking bench for spi_pw_host: directed scenarios then random traffic,
// every cycle compared against a queue-based transaction model.
module tb_spi_pw_host;

  localparam int N     = 4;
  localparam int LOG2  = 2;
  localparam int DEPTH = 4;

  logic           clk;
  logic           rst;
  logic [7:0]     sb_rx_data;
  logic           sb_rx_first;
  logic           sb_rx_stb;
  logic           sb_cs_end;
  logic [7:0]     sb_tx_data;
  logic           sb_tx_valid;
  logic           sb_tx_ack;
  logic [7:0]     pw_wdata;
  logic           pw_wcmd;
  logic           pw_wstb;
  logic           pw_end;
  logic [N-1:0]   pw_req;
  logic [N-1:0]   pw_gnt;
  logic [8*N-1:0] pw_rdata;
  logic [N-1:0]   pw_rstb;
  logic           ovf;

  spi_pw_host #(.N_CLIENTS(N), .FIFO_DEPTH_LOG2(LOG2)) dut (
    .clk(clk), .rst(rst),
    .sb_rx_data(sb_rx_data), .sb_rx_first(sb_rx_first), .sb_rx_stb(sb_rx_stb),
    .sb_cs_end(sb_cs_end), .sb_tx_data(sb_tx_data), .sb_tx_valid(sb_tx_valid),
    .sb_tx_ack(sb_tx_ack), .pw_wdata(pw_wdata), .pw_wcmd(pw_wcmd), .pw_wstb(pw_wstb),
    .pw_end(pw_end), .pw_req(pw_req), .pw_gnt(pw_gnt), .pw_rdata(pw_rdata),
    .pw_rstb(pw_rstb), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: expected registered outputs plus the TX queue contents.
  logic [7:0] m_wdata;
  logic       m_wcmd, m_wstb, m_end, m_ovf;
  int         m_g;
  logic [7:0] m_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int g_next;
    if (rst) begin
      m_wdata = '0; m_wcmd = 0; m_wstb = 0; m_end = 0; m_ovf = 0;
      m_g = -1;
      m_q.delete();
    end else begin
      g_next = m_g;
      if (m_end) begin
        g_next = -1;
        m_q.delete();
        m_ovf = 0;
      end else begin
        if (sb_tx_ack && m_q.size() > 0) void'(m_q.pop_front());
        if (m_g >= 0 && pw_rstb[m_g]) begin
          if (m_q.size() < DEPTH) m_q.push_back(pw_rdata[8*m_g +: 8]);
          else m_ovf = 1;
        end
        if (m_g < 0) begin
          for (int i = 0; i < N; i++) begin
            if (pw_req[i]) begin
              g_next = i;
              break;
            end
          end
        end
      end
      m_g    = g_next;
      m_wstb = sb_rx_stb;
      if (sb_rx_stb) begin
        m_wdata = sb_rx_data;
        m_wcmd  = sb_rx_first;
      end
      m_end = sb_cs_end;
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] eg;
    eg = (m_g < 0) ? '0 : N'(1 << m_g);
    chk("pw_wstb", pw_wstb, m_wstb);
    chk("pw_wdata", pw_wdata, m_wdata);
    chk("pw_wcmd", pw_wcmd, m_wcmd);
    chk("pw_end", pw_end, m_end);
    chk("pw_gnt", pw_gnt, eg);
    chk("ovf", ovf, m_ovf);
    chk("sb_tx_valid", sb_tx_valid, m_q.size() != 0);
    if (m_q.size() != 0) chk("sb_tx_data", sb_tx_data, m_q[0]);
  endtask

  // Inputs change at the falling edge; model and DUT both advance on the rising edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic clr();
    rst = 0; sb_rx_stb = 0; sb_rx_first = 0; sb_cs_end = 0; sb_tx_ack = 0; pw_rstb = '0;
  endtask

  task automatic put(input int c, input logic [7:0] b);
    pw_rdata[8*c +: 8] = b;
    pw_rstb = N'(1 << c);
  endtask

  initial begin
    clr();
    sb_rx_data = '0; pw_req = '0; pw_rdata = '0;
    m_g = -1; m_wdata = '0; m_wcmd = 0; m_wstb = 0; m_end = 0; m_ovf = 0;
    rst = 1;
    @(negedge clk);
    tick();
    rst = 0;
    tick();
    chk("reset_gnt", pw_gnt, 4'b0000);
    chk("reset_valid", sb_tx_valid, 1'b0);
    chk("reset_ovf", ovf, 1'b0);

    // Write path
    sb_rx_stb = 1; sb_rx_first = 1; sb_rx_data = 8'hF1;
    tick();
    chk("cmd_wstb", pw_wstb, 1'b1);
    chk("cmd_wcmd", pw_wcmd, 1'b1);
    chk("cmd_wdata", pw_wdata, 8'hF1);
    sb_rx_first = 0; sb_rx_data = 8'h55;
    tick();
    chk("data_wcmd", pw_wcmd, 1'b0);
    chk("data_wdata", pw_wdata, 8'h55);
    clr();
    tick();
    chk("hold_wdata", pw_wdata, 8'h55);

    // Arbitration
    pw_req = 4'b0110;
    tick();
    chk("arb_low", pw_gnt, 4'b0010);
    pw_req = 4'b0111;
    tick();
    chk("arb_hold", pw_gnt, 4'b0010);
    pw_req = 4'b0000;
    sb_cs_end = 1;
    tick();
    chk("end_pulse", pw_end, 1'b1);
    clr();
    tick();
    chk("end_gnt_clr", pw_gnt, 4'b0000);
    pw_req = 4'b0010;
    tick();
    chk("regrant", pw_gnt, 4'b0010);

    // Responses from client 1, then a stray strobe from client 2
    put(1, 8'hA1); tick();
    chk("head_a1", sb_tx_data, 8'hA1);
    put(1, 8'hA2); tick();
    put(1, 8'hA3); tick();
    clr(); put(2, 8'h77); tick();
    clr(); tick();
    chk("ignore_head", sb_tx_data, 8'hA1);
    sb_tx_ack = 1;
    tick(); chk("pop_a2", sb_tx_data, 8'hA2);
    tick(); chk("pop_a3", sb_tx_data, 8'hA3);
    tick(); chk("pop_empty", sb_tx_valid, 1'b0);
    clr();

    // Overflow then flush
    for (int k = 0; k < 5; k++) begin
      put(1, 8'(8'h10 + k));
      tick();
    end
    clr(); tick();
    chk("ovf_set", ovf, 1'b1);
    chk("ovf_head", sb_tx_data, 8'h10);
    sb_cs_end = 1; tick();
    clr(); tick();
    chk("flush_valid", sb_tx_valid, 1'b0);
    chk("flush_ovf", ovf, 1'b0);
    tick();

    // Byte and end together while holding two response bytes
    put(1, 8'hB1); tick();
    put(1, 8'hB2); tick();
    clr();
    sb_rx_stb = 1; sb_rx_data = 8'h3C; sb_cs_end = 1;
    tick();
    chk("both_wstb", pw_wstb, 1'b1);
    chk("both_wdata", pw_wdata, 8'h3C);
    chk("both_end", pw_end, 1'b1);
    clr(); tick();
    chk("both_valid", sb_tx_valid, 1'b0);
    chk("both_gnt", pw_gnt, 4'b0000);

    // Reset mid-transaction
    tick();
    put(1, 8'hC4); tick();
    clr(); rst = 1; tick();
    chk("rst_gnt", pw_gnt, 4'b0000);
    chk("rst_valid", sb_tx_valid, 1'b0);
    chk("rst_end", pw_end, 1'b0);
    clr();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 299) == 0);
      sb_rx_stb   = ($urandom_range(0, 2) == 0);
      sb_rx_first = 1'($urandom);
      sb_rx_data  = 8'($urandom);
      sb_cs_end   = ($urandom_range(0, 24) == 0);
      sb_tx_ack   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) pw_req = N'($urandom);
      pw_rstb  = N'($urandom);
      pw_rdata = ($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
